// File: rtl/uart_ram_ctrl_if.sv
// UART byte link and single-port RAM signals for uart_ram_ctrl.
// The controller drives through the master modport; the environment uses the slave modport.
interface uart_ram_ctrl_if #(
    parameter int unsigned ADDR_W     = 15,
    parameter int unsigned DATA_BYTES = 1
);
    localparam int unsigned DW = 8 * DATA_BYTES;

    logic [7:0]        uart_rd_data;
    logic              uart_rd_en;
    logic [7:0]        uart_wr_data;
    logic              uart_wr_en;
    logic              uart_wr_complete;
    logic              ram_wr_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [DW-1:0]     ram_wr_data;
    logic [DW-1:0]     ram_rd_data;

    modport master (
        input  uart_rd_data, uart_rd_en, uart_wr_complete, ram_rd_data,
        output uart_wr_data, uart_wr_en, ram_wr_en, ram_addr, ram_wr_data
    );

    modport slave (
        output uart_rd_data, uart_rd_en, uart_wr_complete, ram_rd_data,
        input  uart_wr_data, uart_wr_en, ram_wr_en, ram_addr, ram_wr_data
    );
endinterface

// File: rtl/uart_ram_ctrl.sv
// Byte-command controller between a UART link and a single-port synchronous RAM:
// burst write/read with address wrap-around, write ACK, inter-byte timeout and error pulse.
module uart_ram_ctrl #(
    parameter int unsigned ADDR_W      = 15,
    parameter int unsigned DATA_BYTES  = 1,
    parameter int unsigned RAM_RD_LAT  = 1,
    parameter int unsigned TIMEOUT_CYC = 5_000_000,
    parameter logic [7:0]  ACK_BYTE    = 8'hAC
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    uart_ram_ctrl_if.master bus,
    output logic            busy,
    output logic            cmd_err
);
    localparam int unsigned DW   = 8 * DATA_BYTES;
    localparam int unsigned AB   = (ADDR_W + 7) / 8;
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [7:0]      CMD_WR   = 8'hA5;
    localparam logic [7:0]      CMD_RD   = 8'h5A;
    localparam logic [1:0]      AB_LAST  = 2'(AB - 1);
    localparam logic [1:0]      DB_LAST  = 2'(DATA_BYTES - 1);
    localparam logic [1:0]      LAT_LAST = 2'(RAM_RD_LAT - 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, LEN, WDATA, WCOMMIT, ACK_TX, RD_ISSUE, RD_WAIT, TX_BYTE, TX_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic              is_rd_q, is_rd_d;
    logic [1:0]        cnt_q, cnt_d;      // field byte, word byte or read-latency count
    logic [15:0]       len_q, len_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [DW-1:0]     rdata_q, rdata_d, rdata_sh;
    logic [7:0]        tx_q, tx_d;
    logic              tx_en_q, tx_en_d;
    logic              wr_en_q, wr_en_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              timed_out;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            is_rd_q <= 1'b0;
            cnt_q   <= '0;
            len_q   <= '0;
            to_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            tx_q    <= '0;
            tx_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            is_rd_q <= is_rd_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            to_q    <= to_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            tx_q    <= tx_d;
            tx_en_q <= tx_en_d;
            wr_en_q <= wr_en_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        is_rd_d   = is_rd_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        to_d      = '0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        tx_d      = tx_q;
        tx_en_d   = 1'b0;
        wr_en_d   = 1'b0;
        err_d     = 1'b0;
        timed_out = 1'b0;
        rdata_sh  = rdata_q << 8;

        // Inter-byte timer runs only while a command frame is still arriving.
        if (state_q == ADDR || state_q == LEN || state_q == WDATA) begin
            if (!bus.uart_rd_en) begin
                to_d      = to_q + 1'b1;
                timed_out = (to_q == TO_LAST);
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.uart_rd_en) begin
                    if (bus.uart_rd_data == CMD_WR || bus.uart_rd_data == CMD_RD) begin
                        is_rd_d = (bus.uart_rd_data == CMD_RD);
                        cnt_d   = '0;
                        state_d = ADDR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ADDR: begin
                if (bus.uart_rd_en) begin
                    addr_d = ADDR_W'({addr_q, bus.uart_rd_data});
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == AB_LAST) begin
                        cnt_d   = '0;
                        state_d = LEN;
                    end
                end
            end
            LEN: begin
                if (bus.uart_rd_en) begin
                    len_d = {len_q[7:0], bus.uart_rd_data};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd1) begin
                        cnt_d   = '0;
                        state_d = is_rd_q ? RD_ISSUE : WDATA;
                    end
                end
            end
            WDATA: begin
                if (bus.uart_rd_en) begin
                    wdata_d = DW'({wdata_q, bus.uart_rd_data});
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == DB_LAST) begin
                        cnt_d   = '0;
                        wr_en_d = 1'b1;
                        state_d = WCOMMIT;
                    end
                end
            end
            WCOMMIT: begin
                addr_d = addr_q + 1'b1;
                if (len_q == 16'd0) begin
                    tx_d    = ACK_BYTE;
                    tx_en_d = 1'b1;
                    state_d = ACK_TX;
                end else begin
                    len_d   = len_q - 16'd1;
                    state_d = WDATA;
                end
            end
            ACK_TX:   state_d = TX_WAIT;
            RD_ISSUE: begin
                cnt_d   = '0;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == LAT_LAST) begin
                    rdata_d = bus.ram_rd_data;
                    tx_d    = bus.ram_rd_data[DW-1 -: 8];
                    tx_en_d = 1'b1;
                    cnt_d   = '0;
                    state_d = TX_BYTE;
                end
            end
            TX_BYTE:  state_d = TX_WAIT;
            TX_WAIT: begin
                if (bus.uart_wr_complete) begin
                    if (!is_rd_q) begin
                        state_d = IDLE;
                    end else if (cnt_q != DB_LAST) begin
                        cnt_d   = cnt_q + 2'd1;
                        rdata_d = rdata_sh;
                        tx_d    = rdata_sh[DW-1 -: 8];
                        tx_en_d = 1'b1;
                        state_d = TX_BYTE;
                    end else if (len_q == 16'd0) begin
                        state_d = IDLE;
                    end else begin
                        len_d   = len_q - 16'd1;
                        addr_d  = addr_q + 1'b1;
                        state_d = RD_ISSUE;
                    end
                end
            end
            default:  state_d = IDLE;
        endcase

        // Abandon the frame; words already committed stay in RAM.
        if (timed_out) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
        end

        busy_d = (state_d != IDLE);
    end

    assign bus.uart_wr_data = tx_q;
    assign bus.uart_wr_en   = tx_en_q;
    assign bus.ram_wr_en    = wr_en_q;
    assign bus.ram_addr     = addr_q;
    assign bus.ram_wr_data  = wdata_q;
    assign busy             = busy_q;
    assign cmd_err          = err_q;
endmodule

// File: doc/uart_ram_ctrl.md
# uart_ram_ctrl

Parametrised command controller between the UART byte link and a single-port synchronous RAM. It replaces the fixed 8-bit/15-bit system controller.
- Decodes a byte-oriented command stream from the UART receiver: burst write and burst read with explicit address and length.
- Drives the RAM port and streams read data back through the UART transmitter, one byte per handshake.
- Adds inter-byte timeout, address wrap-around, write acknowledge and error reporting.

## Interface
Parameters:
- ADDR_W, 15, RAM address width (1..24); address field is AB = ceil(ADDR_W/8) bytes.
- DATA_BYTES, 1, RAM word width in bytes (1..4); RAM data width DW = 8*DATA_BYTES.
- RAM_RD_LAT, 1, cycles from ram_addr to valid ram_rd_data (1..3).
- TIMEOUT_CYC, 5_000_000, max sys_clk cycles between received bytes inside a command (100 ms at 50 MHz).
- ACK_BYTE, 8'hAC, byte sent after a completed burst write.

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- sys_rst_n  in  1  asynchronous active-low reset.
- uart_rd_data  in  8  received byte, valid while uart_rd_en is high.
- uart_rd_en  in  1  one-cycle pulse per received byte.
- uart_wr_data  out  8  byte to transmit, held stable from uart_wr_en until uart_wr_complete.
- uart_wr_en  out  1  one-cycle transmit request pulse.
- uart_wr_complete  in  1  one-cycle pulse when the transmitter has finished a byte.
- ram_wr_en  out  1  RAM write strobe, one cycle per word.
- ram_addr  out  ADDR_W  RAM address.
- ram_wr_data  out  DW  RAM write data.
- ram_rd_data  in  DW  RAM read data.
- busy  out  1  high whenever state is not IDLE.
- cmd_err  out  1  one-cycle pulse on an unknown command byte or a timeout.

## Operation
- Frame format: CMD, AB address bytes (MSB first), 2 length bytes L (MSB first), then payload. The burst is L+1 words (1..65536).
  - Address bits above ADDR_W are ignored.
- CMD 8'hA5 is a write. The payload is (L+1)*DATA_BYTES bytes, MSB byte of each word first.
  - Each assembled word is written with a single ram_wr_en pulse; the address then increments.
  - After the last word, the block transmits ACK_BYTE.
- CMD 8'h5A is a read. There is no payload.
  - Per word: the block issues ram_addr, waits RAM_RD_LAT cycles, captures ram_rd_data, then transmits DATA_BYTES bytes MSB first.
  - The address then increments.
- Any other byte received in IDLE pulses cmd_err and is discarded; the block stays in IDLE.
- The address counter is ADDR_W bits wide and wraps from 2^ADDR_W-1 to 0 with no error.
- Length counter is 16 bits; byte-within-word counter is 2 bits.
- States and transitions:
  - IDLE: a valid CMD byte goes to ADDR.
  - ADDR: after AB bytes, go to LEN.
  - LEN: after 2 bytes, go to WDATA (write) or RD_ISSUE (read).
  - WDATA: after the last byte of a word, go to WCOMMIT.
  - WCOMMIT: one cycle. Returns to WDATA if words remain, otherwise goes to ACK_TX.
  - ACK_TX: pulses uart_wr_en, then goes to TX_WAIT.
  - RD_ISSUE: goes to RD_WAIT.
  - RD_WAIT: after RAM_RD_LAT cycles, capture data and go to TX_BYTE.
  - TX_BYTE: pulses uart_wr_en, then goes to TX_WAIT.
  - TX_WAIT: on uart_wr_complete, go to the next byte, next word (RD_ISSUE), or IDLE.
- Timeout:
  - In ADDR, LEN and WDATA, a cycle counter restarts on every uart_rd_en.
  - Reaching TIMEOUT_CYC pulses cmd_err and returns to IDLE.
  - Words already committed in that burst stay written; no ACK is sent.
- uart_rd_en while in RD_*, TX_* or ACK_TX is ignored; the byte is dropped.
- uart_wr_complete outside TX_WAIT is ignored.
- Reset asserted at any point, including mid-burst or mid-transmit, returns the block to IDLE immediately. No ACK and no further writes occur.

## Timing
- Reset values: uart_wr_data=0, uart_wr_en=0, ram_wr_en=0, ram_addr=0, ram_wr_data=0, busy=0, cmd_err=0. All outputs are registered.
- Write path: ram_wr_en, ram_addr and ram_wr_data are valid together in the cycle after the uart_rd_en carrying the word's last byte.
- Read path: ram_addr is valid from RD_ISSUE. ram_rd_data is sampled RAM_RD_LAT cycles later. The first uart_wr_en follows the sample by 1 cycle.
- The next uart_wr_en comes 1 cycle after uart_wr_complete. There is never more than one outstanding transmit.
- busy rises the cycle after the CMD byte. It falls in the cycle after the final uart_wr_complete, or in the timeout/error cycle.
- cmd_err is high for exactly one cycle per event.

## Test plan
- Default parameters, write then read:
  - Write: rx A5 00 10 00 02 11 22 33 → three ram_wr_en pulses at 0x0010/0x0011/0x0012 with data 11/22/33, then tx AC.
  - Read: rx 5A 00 10 00 02 → tx 11 22 33, each byte only after the previous byte's uart_wr_complete.
- Wrap-around: write A5 7F FF 00 01 AA BB → writes 0x7FFF=AA, then 0x0000=BB; tx AC.
- Wide words: DATA_BYTES=2, RAM_RD_LAT=2.
  - Write A5 00 04 00 00 12 34 → a single write of 0x1234 at 0x0004.
  - Read back → tx 12 then 34; the first uart_wr_en comes 3 cycles after RD_ISSUE.
- Errors:
  - rx 00 → one cmd_err pulse, no RAM or UART activity.
  - rx A5 00 → idle for TIMEOUT_CYC (set to 100 for this test) → cmd_err pulse and busy=0.
  - A following valid frame then works normally.
- Reset mid-read: deassert sys_rst_n during TX_WAIT of a 4-word read → all outputs go to 0 at once. After release, no further tx occurs, and a new read returns the correct data.
